// File: rtl/wb_event_ctrl_if.sv
// rtl/wb_event_ctrl_if.sv - writeback event bus between the pipeline and wb_event_ctrl
interface wb_event_ctrl_if;
    logic        clk_en;
    logic        exc_in_wb;
    logic        interrupt_in_wb;
    logic        tlb_exc_in_wb;
    logic        rfe_in_wb;
    logic        rfi_in_wb;
    logic        halt_in_wb;
    logic        sleep_in_wb;
    logic [7:0]  exc_code;
    logic [31:0] wb_pc;
    logic [31:0] wb_addr;
    logic [31:0] epc_in;
    logic        irq_pending;

    logic        flush;
    logic        pipe_hold;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        epc_we;
    logic [31:0] epc_data;
    logic        tlb_addr_we;
    logic [31:0] tlb_addr_data;
    logic        imask_restore;
    logic        kmode;
    logic        halted;
    logic        sleeping;
    logic [2:0]  state_out;
    logic [31:0] exc_count;
    logic [31:0] sleep_cycles;

    modport master (
        output clk_en, exc_in_wb, interrupt_in_wb, tlb_exc_in_wb, rfe_in_wb, rfi_in_wb,
               halt_in_wb, sleep_in_wb, exc_code, wb_pc, wb_addr, epc_in, irq_pending,
        input  flush, pipe_hold, redirect_valid, redirect_pc, epc_we, epc_data,
               tlb_addr_we, tlb_addr_data, imask_restore, kmode, halted, sleeping,
               state_out, exc_count, sleep_cycles
    );

    modport slave (
        input  clk_en, exc_in_wb, interrupt_in_wb, tlb_exc_in_wb, rfe_in_wb, rfi_in_wb,
               halt_in_wb, sleep_in_wb, exc_code, wb_pc, wb_addr, epc_in, irq_pending,
        output flush, pipe_hold, redirect_valid, redirect_pc, epc_we, epc_data,
               tlb_addr_we, tlb_addr_data, imask_restore, kmode, halted, sleeping,
               state_out, exc_count, sleep_cycles
    );
endinterface

// File: rtl/wb_event_ctrl.sv
// rtl/wb_event_ctrl.sv - writeback exception/rfe/halt/sleep sequencer; WB_EVENT_CTRL_PERF_EN adds perf counters
module wb_event_ctrl #(
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    wb_event_ctrl_if.slave     bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXC_SAVE = 3'd1,
        EXC_VEC  = 3'd2,
        RFE      = 3'd3,
        HALTED   = 3'd4,
        SLEEP    = 3'd5
    } state_t;

    state_t      state, state_next;
    logic [7:0]  cap_code;
    logic [31:0] cap_pc;
    logic [31:0] cap_addr;
    logic        cap_tlb;
    logic        cap_rfi;
    logic [31:0] resume_pc;
    logic        kmode_q;

    logic        en;
    logic        take_exc, take_rfe, take_halt, take_sleep;
    logic        wake;
    logic        flush_c, hold_c, redir_c, epc_we_c, tlb_we_c, imask_c;
    logic [31:0] redir_pc_c;

    // Reset also gates strobes so a sequence interrupted by rst emits nothing more.
    assign en         = bus.clk_en && !rst;
    assign take_exc   = en && (state == IDLE) && (bus.exc_in_wb || bus.interrupt_in_wb);
    assign take_rfe   = en && (state == IDLE) && !take_exc && bus.rfe_in_wb;
    assign take_halt  = en && (state == IDLE) && !take_exc && !bus.rfe_in_wb && bus.halt_in_wb;
    assign take_sleep = en && (state == IDLE) && !take_exc && !bus.rfe_in_wb &&
                        !bus.halt_in_wb && bus.sleep_in_wb;
    assign wake       = en && (state == SLEEP) && bus.irq_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (bus.clk_en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        flush_c    = 1'b0;
        hold_c     = 1'b1;
        redir_c    = 1'b0;
        redir_pc_c = 32'h0;
        epc_we_c   = 1'b0;
        tlb_we_c   = 1'b0;
        imask_c    = 1'b0;
        case (state)
            IDLE: begin
                hold_c  = 1'b0;
                flush_c = take_exc || take_rfe || take_halt || take_sleep;
                if (take_exc)        state_next = EXC_SAVE;
                else if (take_rfe)   state_next = RFE;
                else if (take_halt)  state_next = HALTED;
                else if (take_sleep) state_next = SLEEP;
            end
            EXC_SAVE: begin
                epc_we_c   = en;
                tlb_we_c   = en && cap_tlb;
                state_next = EXC_VEC;
            end
            EXC_VEC: begin
                redir_c    = en;
                redir_pc_c = VECTOR_BASE + {22'h0, cap_code, 2'b00};
                state_next = IDLE;
            end
            RFE: begin
                redir_c    = en;
                redir_pc_c = bus.epc_in;
                imask_c    = en && cap_rfi;
                state_next = IDLE;
            end
            HALTED: begin
                state_next = HALTED;
            end
            SLEEP: begin
                redir_pc_c = resume_pc;
                if (wake) begin
                    redir_c    = 1'b1;
                    hold_c     = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_code  <= 8'h0;
            cap_pc    <= 32'h0;
            cap_addr  <= 32'h0;
            cap_tlb   <= 1'b0;
            cap_rfi   <= 1'b0;
            resume_pc <= 32'h0;
            kmode_q   <= 1'b1;
        end else if (bus.clk_en) begin
            if (take_exc) begin
                cap_code <= bus.exc_code;
                cap_pc   <= bus.wb_pc;
                cap_addr <= bus.wb_addr;
                cap_tlb  <= bus.tlb_exc_in_wb;
            end
            if (take_rfe)   cap_rfi   <= bus.rfi_in_wb;
            if (take_sleep) resume_pc <= bus.wb_pc + 32'd4;
            if (state == EXC_VEC)  kmode_q <= 1'b1;
            else if (state == RFE) kmode_q <= 1'b0;
        end
    end

`ifdef WB_EVENT_CTRL_PERF_EN
    logic [31:0] exc_cnt;
    logic [31:0] sleep_cnt;

    // The wake cycle is not counted: sleep_cycles reports cycles spent waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_cnt   <= 32'h0;
            sleep_cnt <= 32'h0;
        end else if (bus.clk_en) begin
            if (state == EXC_VEC) exc_cnt <= exc_cnt + 32'd1;
            if (state == SLEEP && !bus.irq_pending) sleep_cnt <= sleep_cnt + 32'd1;
        end
    end

    assign bus.exc_count    = exc_cnt;
    assign bus.sleep_cycles = sleep_cnt;
`else
    assign bus.exc_count    = 32'h0;
    assign bus.sleep_cycles = 32'h0;
`endif

    assign bus.flush          = flush_c;
    assign bus.pipe_hold      = hold_c;
    assign bus.redirect_valid = redir_c;
    assign bus.redirect_pc    = redir_pc_c;
    assign bus.epc_we         = epc_we_c;
    assign bus.epc_data       = cap_pc;
    assign bus.tlb_addr_we    = tlb_we_c;
    assign bus.tlb_addr_data  = cap_addr;
    assign bus.imask_restore  = imask_c;
    assign bus.kmode          = kmode_q;
    assign bus.halted         = (state == HALTED) && !rst;
    assign bus.sleeping       = (state == SLEEP) && !rst;
    assign bus.state_out      = state;
endmodule

// File: tb/tb_wb_event_ctrl.sv
// tb/tb_wb_event_ctrl.sv - directed scoreboard bench for wb_event_ctrl
module tb_wb_event_ctrl;
    localparam logic [31:0] VB = 32'h0000_0000;
    localparam int K_EPC = 0, K_TLB = 1, K_RED = 2, K_IMK = 3;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    sb_t  sbq[$];

    wb_event_ctrl_if bus ();

    wb_event_ctrl #(.VECTOR_BASE(VB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input int kind, input logic [31:0] data);
        sb_t e;
        e.kind = kind;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [31:0] data);
        sb_t e;
        if (sbq.size() == 0) begin
            chk("sb_unexpected_strobe", kind, 32'hFFFF_FFFF);
        end else begin
            e = sbq.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_data", data, e.data);
        end
    endtask

    // Strobes are taken off the scoreboard in the same fixed order they were pushed.
    always @(negedge clk) begin
        if (bus.epc_we)         pop_cmp(K_EPC, bus.epc_data);
        if (bus.tlb_addr_we)    pop_cmp(K_TLB, bus.tlb_addr_data);
        if (bus.redirect_valid) pop_cmp(K_RED, bus.redirect_pc);
        if (bus.imask_restore)  pop_cmp(K_IMK, 32'h1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        bus.exc_in_wb       = 1'b0;
        bus.interrupt_in_wb = 1'b0;
        bus.tlb_exc_in_wb   = 1'b0;
        bus.rfe_in_wb       = 1'b0;
        bus.rfi_in_wb       = 1'b0;
        bus.halt_in_wb      = 1'b0;
        bus.sleep_in_wb     = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.clk_en      = 1'b1;
        clear_events();
        bus.exc_code    = 8'h0;
        bus.wb_pc       = 32'h0;
        bus.wb_addr     = 32'h0;
        bus.epc_in      = 32'h0;
        bus.irq_pending = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rst_state", bus.state_out, 32'd0);
        chk("rst_kmode", bus.kmode, 1'b1);
        chk("rst_hold", bus.pipe_hold, 1'b0);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_sleeping", bus.sleeping, 1'b0);
        chk("rst_exc_count", bus.exc_count, 32'h0);

        // rfe with rfi
        bus.rfe_in_wb = 1'b1; bus.rfi_in_wb = 1'b1; bus.epc_in = 32'h4000;
        push(K_RED, 32'h4000); push(K_IMK, 32'h1);
        #1 chk("rfe_flush", bus.flush, 1'b1);
        next_cycle(); clear_events();
        #1 chk("rfe_state", bus.state_out, 32'd3);
        chk("rfe_redirect", bus.redirect_valid, 1'b1);
        chk("rfe_imask", bus.imask_restore, 1'b1);
        next_cycle();
        #1 chk("rfe_kmode", bus.kmode, 1'b0);
        chk("rfe_idle", bus.state_out, 32'd0);
        chk("rfe_redirect_once", bus.redirect_valid, 1'b0);

        // rfe without rfi
        bus.rfe_in_wb = 1'b1;
        push(K_RED, 32'h4000);
        next_cycle(); clear_events();
        #1 chk("rfe2_imask", bus.imask_restore, 1'b0);
        next_cycle();

        // fault with TLB flag; rfe simultaneously loses on priority
        bus.exc_in_wb = 1'b1; bus.rfe_in_wb = 1'b1; bus.tlb_exc_in_wb = 1'b1;
        bus.exc_code = 8'h82; bus.wb_pc = 32'h1000; bus.wb_addr = 32'hDEAD0;
        push(K_EPC, 32'h1000); push(K_TLB, 32'hDEAD0); push(K_RED, VB + 32'h208);
        #1 chk("exc_flush", bus.flush, 1'b1);
        next_cycle(); clear_events();
        #1 chk("exc_save_state", bus.state_out, 32'd1);
        chk("exc_epc_we", bus.epc_we, 1'b1);
        chk("exc_tlb_we", bus.tlb_addr_we, 1'b1);
        chk("exc_hold", bus.pipe_hold, 1'b1);
        chk("exc_flush_n1", bus.flush, 1'b0);
        next_cycle();
        #1 chk("exc_vec_state", bus.state_out, 32'd2);
        chk("exc_redirect_pc", bus.redirect_pc, 32'h208);
        next_cycle();
        #1 chk("exc_kmode", bus.kmode, 1'b1);
        chk("exc_idle", bus.state_out, 32'd0);

        // interrupt behaves as a fault; no TLB write without the flag
        bus.interrupt_in_wb = 1'b1; bus.exc_code = 8'h01; bus.wb_pc = 32'h0000_0ABC;
        push(K_EPC, 32'h0000_0ABC); push(K_RED, VB + 32'h4);
        next_cycle(); clear_events();
        #1 chk("irq_tlb_we", bus.tlb_addr_we, 1'b0);
        next_cycle();
        next_cycle();

        // clk_en low blocks acceptance
        bus.clk_en = 1'b0; bus.halt_in_wb = 1'b1;
        #1 chk("noen_flush", bus.flush, 1'b0);
        next_cycle(); clear_events(); bus.clk_en = 1'b1;
        #1 chk("noen_state", bus.state_out, 32'd0);

        // stall in EXC_SAVE, then reset in EXC_VEC
        bus.exc_in_wb = 1'b1; bus.exc_code = 8'h03; bus.wb_pc = 32'h2000;
        push(K_EPC, 32'h2000);
        next_cycle(); clear_events(); bus.clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_epc_we", bus.epc_we, 1'b0);
            chk("stall_hold", bus.pipe_hold, 1'b1);
            chk("stall_state", bus.state_out, 32'd1);
            next_cycle();
        end
        bus.clk_en = 1'b1;
        #1 chk("stall_epc_we_back", bus.epc_we, 1'b1);
        next_cycle();
        rst = 1'b1;
        #1 chk("rstvec_state", bus.state_out, 32'd2);
        chk("rstvec_redirect", bus.redirect_valid, 1'b0);
        next_cycle(); rst = 1'b0;
        #1 chk("rstvec_idle", bus.state_out, 32'd0);

        // sleep with resume PC wrap
        bus.sleep_in_wb = 1'b1; bus.wb_pc = 32'hFFFF_FFFC; bus.irq_pending = 1'b0;
        push(K_RED, 32'h0);
        #1 chk("slp_flush", bus.flush, 1'b1);
        next_cycle(); clear_events();
        for (int i = 0; i < 5; i++) begin
            #1 chk("slp_sleeping", bus.sleeping, 1'b1);
            chk("slp_hold", bus.pipe_hold, 1'b1);
            next_cycle();
        end
        bus.irq_pending = 1'b1;
        #1 chk("slp_wake_hold", bus.pipe_hold, 1'b0);
        chk("slp_wake_redirect", bus.redirect_valid, 1'b1);
        next_cycle(); bus.irq_pending = 1'b0;
        #1 chk("slp_idle", bus.state_out, 32'd0);
`ifdef WB_EVENT_CTRL_PERF_EN
        chk("slp_cycles", bus.sleep_cycles, 32'd5);
`else
        chk("slp_cycles", bus.sleep_cycles, 32'd0);
`endif

        // halt beats sleep; later events ignored until reset
        bus.halt_in_wb = 1'b1; bus.sleep_in_wb = 1'b1;
        #1 chk("halt_flush", bus.flush, 1'b1);
        next_cycle(); clear_events();
        bus.exc_in_wb = 1'b1; bus.rfe_in_wb = 1'b1; bus.sleep_in_wb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("halt_state", bus.state_out, 32'd4);
            chk("halt_halted", bus.halted, 1'b1);
            chk("halt_sleeping", bus.sleeping, 1'b0);
            chk("halt_flush_ign", bus.flush, 1'b0);
            next_cycle();
        end
        clear_events();
        rst = 1'b1;
        next_cycle(); rst = 1'b0;
        #1 chk("halt_rst_state", bus.state_out, 32'd0);
        chk("halt_rst_kmode", bus.kmode, 1'b1);
        chk("halt_rst_halted", bus.halted, 1'b0);

        next_cycle();
        chk("sb_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
